// File: rtl/sudoku_grid_validator.sv
// rtl/sudoku_grid_validator.sv - 9x9 grid checker: cell range pass, then 27 units one per cycle.
module sudoku_grid_validator #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [323:0]     puz_in,
    input  logic             next_p,
    output logic             busy,
    output logic             solution,
    output logic             give_up,
    output logic [4:0]       fail_unit,
    output logic [CNT_W-1:0] num_pass,
    output logic [CNT_W-1:0] num_fail
);

    typedef enum logic [1:0] {S_IDLE, S_RANGE, S_SCAN, S_DONE} state_t;

    state_t       r_state;
    logic [323:0] r_grid;
    logic [4:0]   r_unit;
    logic [6:0]   w_cells [9];
    logic [8:0]   w_mask;
    logic         w_illegal;

    // Units 0-8 are rows, 9-17 columns, 18-26 boxes; k walks the 9 cells of the unit.
    function automatic logic [6:0] cell_of(input logic [4:0] unit, input logic [3:0] k);
        logic [6:0] row;
        logic [6:0] col;
        logic [6:0] b;
        b = '0;
        if (unit < 5'd9) begin
            row = 7'(unit);
            col = 7'(k);
        end else if (unit < 5'd18) begin
            row = 7'(k);
            col = 7'(unit - 5'd9);
        end else begin
            b   = 7'(unit - 5'd18);
            row = 7'd3 * (b / 7'd3) + 7'(k / 4'd3);
            col = 7'd3 * (b % 7'd3) + 7'(k % 4'd3);
        end
        return row * 7'd9 + col;
    endfunction

    function automatic logic [8:0] onehot(input logic [3:0] d);
        if (d >= 4'd1 && d <= 4'd9)
            return 9'd1 << (d - 4'd1);
        else
            return '0;
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++)
            w_cells[k] = cell_of(r_unit, 4'(k));
    end

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < 9; k++)
            w_mask = w_mask | onehot(r_grid[{w_cells[k], 2'b00} +: 4]);
    end

    always_comb begin
        w_illegal = 1'b0;
        for (int i = 0; i < 81; i++)
            if (r_grid[4*i +: 4] > 4'd9)
                w_illegal = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_grid    <= '0;
            r_unit    <= '0;
            busy      <= 1'b0;
            solution  <= 1'b0;
            give_up   <= 1'b0;
            fail_unit <= 5'd31;
            num_pass  <= '0;
            num_fail  <= '0;
        end else begin
            solution <= 1'b0;
            give_up  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (next_p) begin
                        r_grid    <= puz_in;
                        fail_unit <= 5'd31;
                        busy      <= 1'b1;
                        r_state   <= S_RANGE;
                    end
                end
                S_RANGE: begin
                    if (w_illegal) begin
                        fail_unit <= 5'd27;
                        give_up   <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_unit  <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_mask != 9'h1FF) begin
                        fail_unit <= r_unit;
                        give_up   <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_unit == 5'd26) begin
                        solution <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_unit <= r_unit + 5'd1;
                    end
                end
                S_DONE: begin
                    // The result pulse itself records which tally to bump.
                    if (solution) begin
                        if (num_pass != '1)
                            num_pass <= num_pass + CNT_W'(1);
                    end else if (num_fail != '1) begin
                        num_fail <= num_fail + CNT_W'(1);
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_grid_validator.sv
// tb/tb_sudoku_grid_validator.sv - directed bench for sudoku_grid_validator.
module tb_sudoku_grid_validator;

    logic         clk;
    logic         rst;
    logic [323:0] puz_in;
    logic         next_p;
    logic         busy;
    logic         solution;
    logic         give_up;
    logic [4:0]   fail_unit;
    logic [1:0]   num_pass;
    logic [1:0]   num_fail;

    int n_checks;
    int n_fail;

    sudoku_grid_validator #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .puz_in    (puz_in),
        .next_p    (next_p),
        .busy      (busy),
        .solution  (solution),
        .give_up   (give_up),
        .fail_unit (fail_unit),
        .num_pass  (num_pass),
        .num_fail  (num_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [323:0] std_grid();
        logic [323:0] g;
        g = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g[4*(9*r+c) +: 4] = 4'(((c + 3*r + r/3) % 9) + 1);
        return g;
    endfunction

    function automatic logic [323:0] latin_grid();
        logic [323:0] g;
        g = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g[4*(9*r+c) +: 4] = 4'(((r + c) % 9) + 1);
        return g;
    endfunction

    // Accept a grid at E0, expect the result pulse in cycle E<exp_cyc>..E<exp_cyc+1>.
    task automatic run_grid(input string tag, input logic [323:0] g, input int exp_cyc,
                            input bit exp_pass, input logic [4:0] exp_fu, input logic [1:0] exp_cnt);
        bit early;
        puz_in = g;
        next_p = 1'b1;
        tick();
        next_p = 1'b0;
        puz_in = '0;
        early  = 1'b0;
        for (int c = 1; c < exp_cyc; c++) begin
            tick();
            if (solution || give_up || !busy) early = 1'b1;
        end
        check({tag, "_early"}, 32'(early), 32'd0);
        tick();
        check({tag, "_solution"}, 32'(solution), 32'(exp_pass));
        check({tag, "_give_up"}, 32'(give_up), 32'(!exp_pass));
        check({tag, "_fail_unit"}, 32'(fail_unit), 32'(exp_fu));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_pulse_end"}, 32'(solution | give_up), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_fu_hold"}, 32'(fail_unit), 32'(exp_fu));
        check({tag, "_tally"}, 32'(exp_pass ? num_pass : num_fail), 32'(exp_cnt));
    endtask

    initial begin
        logic [323:0] g;
        int  pc [5];
        int  npulse;
        int  nchecked;
        bit  prev_sol;
        bit  seen;
        logic [1:0] exp_np [5];

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        next_p   = 1'b0;
        puz_in   = '0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'(solution | give_up), 32'd0);
        check("rst_fail_unit", 32'(fail_unit), 32'd31);
        check("rst_tallies", 32'({num_pass, num_fail}), 32'd0);
        rst = 1'b1;
        tick();

        run_grid("t1_valid", std_grid(), 28, 1'b1, 5'd31, 2'd1);

        g = std_grid();
        g[4*40 +: 4] = 4'd0;
        run_grid("t2_row4", g, 6, 1'b0, 5'd4, 2'd1);

        run_grid("t3_box0", latin_grid(), 20, 1'b0, 5'd18, 2'd2);

        // Illegal cell, with a stray request while the check is in flight.
        g = std_grid();
        g[4*80 +: 4] = 4'hC;
        puz_in = g;
        next_p = 1'b1;
        tick();
        tick();
        check("t4_give_up", 32'(give_up), 32'd1);
        check("t4_fail_unit", 32'(fail_unit), 32'd27);
        next_p = 1'b0;
        tick();
        check("t4_pulse_end", 32'(give_up), 32'd0);
        check("t4_num_fail", 32'(num_fail), 32'd3);
        tick();
        check("t4_not_queued", 32'(busy), 32'd0);

        // Back-to-back with saturating 2-bit tally.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_np   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        npulse   = 0;
        nchecked = 0;
        prev_sol = 1'b0;
        puz_in   = std_grid();
        next_p   = 1'b1;
        for (int c = 0; c < 200 && nchecked < 5; c++) begin
            tick();
            if (prev_sol) begin
                check($sformatf("t5_num_pass_%0d", nchecked), 32'(num_pass), 32'(exp_np[nchecked]));
                nchecked++;
            end
            prev_sol = solution;
            if (solution && npulse < 5) begin
                pc[npulse] = c;
                npulse++;
            end
        end
        next_p = 1'b0;
        check("t5_pulse_count", 32'(npulse), 32'd5);
        check("t5_first_pulse", 32'(pc[0]), 32'd28);
        for (int i = 0; i < 4; i++)
            if (i + 1 < npulse)
                check($sformatf("t5_spacing_%0d", i), 32'(pc[i+1] - pc[i]), 32'd30);
        tick();
        check("t5_idle", 32'(busy), 32'd0);

        // Reset in the middle of a check.
        puz_in = std_grid();
        next_p = 1'b1;
        tick();
        next_p = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_tallies", 32'({num_pass, num_fail}), 32'd0);
        check("t6_fail_unit", 32'(fail_unit), 32'd31);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (solution || give_up) seen = 1'b1;
        end
        check("t6_no_pulse", 32'(seen), 32'd0);
        run_grid("t6_after", std_grid(), 28, 1'b1, 5'd31, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
